multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath's muxes, register and memory enables, and ALU operation code. It sits between the instruction register and the shared datapath, and stalls on a memory ready handshake so a single shared memory serves both instructions and data.

---
 rtl/multicycle_control.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle Moore sequencer for the MIPS datapath: fetch, decode, execute, memory, writeback.
// Define MC_CTRL_BYTE_HALF_EN to decode lb/lh/sb/sh and drive sub-word mem_size.
module multicycle_control #(
  parameter logic [5:0] JR_FUNCT = 6'b001000,
  parameter int         STATE_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         mem_size,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               jal,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [5:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R,
    R_WB, EXEC_I, I_WB, BRANCH, JUMP, JR, JAL_WB, ILLEGAL
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_n;

  logic       pc_en_q, iord_q, mem_read_q, mem_write_q, reg_dst_q, reg_write_q;
  logic       mem_to_reg_q, jal_q, alu_src_a_q, illegal_q, fetch_q, branch_q, br_inv_q;
  logic [1:0] alu_src_b_q, pc_source_q;
  logic [5:0] alu_op_q;

  function automatic state_e decode_op(input logic [5:0] op, input logic [5:0] fn);
    state_e s;
    case (op)
      6'b000000: s = (fn == JR_FUNCT) ? JR : EXEC_R;
      6'b001000, 6'b011111, 6'b001100,
      6'b001101, 6'b001010, 6'b001111: s = EXEC_I;
      6'b100011, 6'b101011: s = MEM_ADDR;
`ifdef MC_CTRL_BYTE_HALF_EN
      6'b100000, 6'b100001, 6'b101000, 6'b101001: s = MEM_ADDR;
`endif
      6'b000100, 6'b000101, 6'b000001: s = BRANCH;
      6'b000010: s = JUMP;
      6'b000011: s = JAL_WB;
      default:   s = ILLEGAL;
    endcase
    return s;
  endfunction

  function automatic logic [5:0] branch_alu_op(input logic [5:0] op);
    case (op)
      6'b000100: return 6'b000001;
      6'b000101: return 6'b000101;
      default:   return 6'b111111;
    endcase
  endfunction

  // The opcode is captured leaving DECODE; outputs registered on that same edge need the live copy.
  always_comb op_n = (state_q == DECODE) ? opcode : op_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE:   state_d = decode_op(opcode, funct);
      EXEC_R:   state_d = R_WB;
      EXEC_I:   state_d = I_WB;
      MEM_ADDR: state_d = op_q[3] ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
      default:  state_d = FETCH;
    endcase
  end

`ifdef MC_CTRL_BYTE_HALF_EN
  logic [1:0] mem_size_q;

  // Word ops end in 11; byte ops in 00 and halfword ops in 01.
  function automatic logic [1:0] size_of(input logic [1:0] op_lo);
    case (op_lo)
      2'b00:   return 2'b10;
      2'b01:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_size_q <= 2'b00;
    end else if (state_d == MEM_RD || state_d == MEM_WR) begin
      mem_size_q <= size_of(op_n[1:0]);
    end else begin
      mem_size_q <= 2'b00;
    end
  end

  assign mem_size = mem_size_q;
`else
  assign mem_size = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 6'b0;
      pc_en_q      <= 1'b0;
      iord_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      jal_q        <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= 6'b0;
      pc_source_q  <= 2'b00;
      illegal_q    <= 1'b0;
      fetch_q      <= 1'b0;
      branch_q     <= 1'b0;
      br_inv_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
      pc_en_q      <= 1'b0;
      iord_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      jal_q        <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= 6'b0;
      pc_source_q  <= 2'b00;
      illegal_q    <= 1'b0;
      fetch_q      <= 1'b0;
      branch_q     <= 1'b0;
      br_inv_q     <= 1'b0;
      case (state_d)
        FETCH:    begin mem_read_q <= 1'b1; alu_src_b_q <= 2'b01; fetch_q <= 1'b1; end
        DECODE:   alu_src_b_q <= 2'b11;
        MEM_ADDR: begin alu_src_a_q <= 1'b1; alu_src_b_q <= 2'b10; end
        MEM_RD:   begin mem_read_q <= 1'b1; iord_q <= 1'b1; end
        MEM_WB:   begin reg_write_q <= 1'b1; mem_to_reg_q <= 1'b1; end
        MEM_WR:   begin mem_write_q <= 1'b1; iord_q <= 1'b1; end
        EXEC_R:   begin alu_src_a_q <= 1'b1; alu_op_q <= 6'b000010; end
        R_WB:     begin reg_dst_q <= 1'b1; reg_write_q <= 1'b1; end
        EXEC_I:   begin alu_src_a_q <= 1'b1; alu_src_b_q <= 2'b10; alu_op_q <= op_n; end
        I_WB:     reg_write_q <= 1'b1;
        BRANCH: begin
          alu_src_a_q <= 1'b1;
          pc_source_q <= 2'b01;
          alu_op_q    <= branch_alu_op(op_n);
          branch_q    <= 1'b1;
          br_inv_q    <= (op_n == 6'b000101);
        end
        JUMP:     begin pc_en_q <= 1'b1; pc_source_q <= 2'b10; end
        JR:       begin pc_en_q <= 1'b1; pc_source_q <= 2'b11; end
        JAL_WB:   begin pc_en_q <= 1'b1; pc_source_q <= 2'b10; reg_write_q <= 1'b1; jal_q <= 1'b1; end
        ILLEGAL:  illegal_q <= 1'b1;
        default:  ;
      endcase
    end
  end

  // Fetch advance and branch resolution depend on same-cycle handshake/flag inputs.
  assign ir_write   = fetch_q & mem_ready;
  assign pc_en      = pc_en_q | (fetch_q & mem_ready) | (branch_q & (zero ^ br_inv_q));
  assign iord       = iord_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign reg_dst    = reg_dst_q;
  assign reg_write  = reg_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign jal        = jal_q;
  assign alu_src_a  = alu_src_a_q;
  assign alu_src_b  = alu_src_b_q;
  assign alu_op     = alu_op_q;
  assign pc_source  = pc_source_q;
  assign illegal_op = illegal_q;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected state sequence plus per-state output table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, reg_write;
  logic       mem_to_reg, jal, alu_src_a, illegal_op;
  logic [1:0] mem_size, alu_src_b, pc_source;
  logic [5:0] alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .ir_write(ir_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .jal(jal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3, ST_MEM_RD = 4;
  localparam int ST_MEM_WB = 5, ST_MEM_WR = 6, ST_EXEC_R = 7, ST_R_WB = 8, ST_EXEC_I = 9;
  localparam int ST_I_WB = 10, ST_BRANCH = 11, ST_JUMP = 12, ST_JR = 13, ST_JAL_WB = 14;
  localparam int ST_ILLEGAL = 15;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_J = 5, C_JR = 6;
  localparam int C_JAL = 7, C_ILL = 8;

  typedef struct packed {
    logic       pc_en, iord, mem_read, mem_write;
    logic [1:0] mem_size;
    logic       ir_write, reg_dst, reg_write, mem_to_reg, jal, alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         wf;
    int         wm;
    int         lat;
    int         nrw;
    int         nill;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rw_cnt = 0;
  int         ill_cnt = 0;
  int         exp_st;
  logic [5:0] m_op;
  vec_t       vecs[$];

  function automatic int class_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return (fn == 6'b001000) ? C_JR : C_R;
    if (op inside {6'b001000, 6'b011111, 6'b001100, 6'b001101, 6'b001010, 6'b001111}) return C_I;
    if (op == 6'b100011) return C_LD;
    if (op == 6'b101011) return C_ST;
`ifdef MC_CTRL_BYTE_HALF_EN
    if (op == 6'b100000 || op == 6'b100001) return C_LD;
    if (op == 6'b101000 || op == 6'b101001) return C_ST;
`endif
    if (op inside {6'b000100, 6'b000101, 6'b000001}) return C_BR;
    if (op == 6'b000010) return C_J;
    if (op == 6'b000011) return C_JAL;
    return C_ILL;
  endfunction

  function automatic logic [1:0] exp_size(input logic [5:0] op);
`ifdef MC_CTRL_BYTE_HALF_EN
    if (op == 6'b100000 || op == 6'b101000) return 2'b10;
    if (op == 6'b100001 || op == 6'b101001) return 2'b01;
`endif
    if (op == 6'b000000) return 2'b11;  // never reached for memory states; keeps op used
    return 2'b00;
  endfunction

  function automatic obs_t exp_outs(input int st, input logic [5:0] op, input logic z,
                                    input logic mr);
    obs_t o;
    o = '0;
    o.state = 4'(st);
    case (st)
      ST_FETCH:    begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
      ST_DECODE:   o.alu_src_b = 2'b11;
      ST_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      ST_MEM_RD:   begin o.mem_read = 1; o.iord = 1; o.mem_size = exp_size(op); end
      ST_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
      ST_MEM_WR:   begin o.mem_write = 1; o.iord = 1; o.mem_size = exp_size(op); end
      ST_EXEC_R:   begin o.alu_src_a = 1; o.alu_op = 6'b000010; end
      ST_R_WB:     begin o.reg_dst = 1; o.reg_write = 1; end
      ST_EXEC_I:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = op; end
      ST_I_WB:     o.reg_write = 1;
      ST_BRANCH: begin
        o.alu_src_a = 1;
        o.pc_source = 2'b01;
        if (op == 6'b000100)      begin o.alu_op = 6'b000001; o.pc_en = z;  end
        else if (op == 6'b000101) begin o.alu_op = 6'b000101; o.pc_en = !z; end
        else                      begin o.alu_op = 6'b111111; o.pc_en = z;  end
      end
      ST_JUMP:     begin o.pc_en = 1; o.pc_source = 2'b10; end
      ST_JR:       begin o.pc_en = 1; o.pc_source = 2'b11; end
      ST_JAL_WB:   begin o.pc_en = 1; o.pc_source = 2'b10; o.reg_write = 1; o.jal = 1; end
      ST_ILLEGAL:  o.illegal_op = 1;
      default:     ;
    endcase
    return o;
  endfunction

  task automatic cmp_cycle();
    obs_t act, exp;
    act = '{pc_en, iord, mem_read, mem_write, mem_size, ir_write, reg_dst, reg_write,
            mem_to_reg, jal, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state};
    exp = exp_outs(exp_st, m_op, zero, mem_ready);
    checks++;
    cyc++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs cyc=%0d exp_state=%0d actual=%h expected=%h", cyc, exp_st, act, exp);
    end
    if (reg_write)  rw_cnt++;
    if (illegal_op) ill_cnt++;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int st, input logic mr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    exp_st    = st;
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic run_instr(input vec_t v, input bit abort, input string name);
    int   st_q[$];
    logic mr_q[$];
    int   rw0, ill0, cls;
    cls  = class_of(v.op, v.fn);
    rw0  = rw_cnt;
    ill0 = ill_cnt;
    for (int i = 0; i < v.wf; i++) begin st_q.push_back(ST_FETCH); mr_q.push_back(1'b0); end
    st_q.push_back(ST_FETCH);  mr_q.push_back(1'b1);
    st_q.push_back(ST_DECODE); mr_q.push_back(1'($urandom_range(0, 1)));
    case (cls)
      C_R:   begin st_q.push_back(ST_EXEC_R); st_q.push_back(ST_R_WB); end
      C_I:   begin st_q.push_back(ST_EXEC_I); st_q.push_back(ST_I_WB); end
      C_BR:  st_q.push_back(ST_BRANCH);
      C_J:   st_q.push_back(ST_JUMP);
      C_JR:  st_q.push_back(ST_JR);
      C_JAL: st_q.push_back(ST_JAL_WB);
      C_ILL: st_q.push_back(ST_ILLEGAL);
      default: begin
        st_q.push_back(ST_MEM_ADDR);
        mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < v.wm; i++) begin
          st_q.push_back(cls == C_LD ? ST_MEM_RD : ST_MEM_WR);
          mr_q.push_back(1'b0);
        end
        if (!abort) begin
          st_q.push_back(cls == C_LD ? ST_MEM_RD : ST_MEM_WR);
          mr_q.push_back(1'b1);
          if (cls == C_LD) st_q.push_back(ST_MEM_WB);
        end
      end
    endcase
    while (mr_q.size() < st_q.size()) mr_q.push_back(1'($urandom_range(0, 1)));
    if (!abort) check_int({name, "_latency"}, st_q.size(), v.lat);
    opcode = v.op;
    funct  = v.fn;
    zero   = v.z;
    m_op   = v.op;
    for (int i = 0; i < st_q.size(); i++) begin
      @(posedge clk);
      #1;
      if (i > 0 && st_q[i-1] == ST_DECODE) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      mem_ready = mr_q[i];
      exp_st    = st_q[i];
      @(negedge clk);
      cmp_cycle();
    end
    if (!abort) begin
      check_int({name, "_reg_write_pulses"}, rw_cnt - rw0, v.nrw);
      check_int({name, "_illegal_pulses"}, ill_cnt - ill0, v.nill);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n  = 1'b0;
    exp_st = ST_IDLE;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      cmp_cycle();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cmp_cycle();
  endtask

  initial begin
    vec_t ab;
    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 6'b0; funct = 6'b0; m_op = 6'b0;
    exp_st = ST_IDLE;
    //                 op         fn         z  wf wm lat rw ill
    vecs.push_back('{6'b000000, 6'b100000, 0, 0, 0, 4, 1, 0});  // add
    vecs.push_back('{6'b000000, 6'b100000, 0, 2, 0, 6, 1, 0});  // add, fetch waits
    vecs.push_back('{6'b001000, 6'b111111, 0, 0, 0, 4, 1, 0});  // addi
    vecs.push_back('{6'b001010, 6'b000000, 1, 0, 0, 4, 1, 0});  // slti
    vecs.push_back('{6'b001111, 6'b000000, 0, 1, 0, 5, 1, 0});  // lui, fetch wait
    vecs.push_back('{6'b100011, 6'b000000, 0, 0, 3, 8, 1, 0});  // lw, 3 waits
    vecs.push_back('{6'b100011, 6'b000000, 1, 0, 0, 5, 1, 0});  // lw
    vecs.push_back('{6'b101011, 6'b000000, 0, 0, 1, 5, 0, 0});  // sw, 1 wait
    vecs.push_back('{6'b000100, 6'b000000, 1, 0, 0, 3, 0, 0});  // beq taken
    vecs.push_back('{6'b000101, 6'b000000, 1, 0, 0, 3, 0, 0});  // bne not taken
    vecs.push_back('{6'b000101, 6'b000000, 0, 0, 0, 3, 0, 0});  // bne taken
    vecs.push_back('{6'b000001, 6'b000000, 0, 0, 0, 3, 0, 0});  // bez not taken
    vecs.push_back('{6'b000010, 6'b000000, 0, 0, 0, 3, 0, 0});  // j
    vecs.push_back('{6'b000000, 6'b001000, 0, 0, 0, 3, 0, 0});  // jr
    vecs.push_back('{6'b000011, 6'b000000, 0, 0, 0, 3, 1, 0});  // jal
    vecs.push_back('{6'b111000, 6'b000000, 0, 0, 0, 3, 0, 1});  // unsupported
`ifdef MC_CTRL_BYTE_HALF_EN
    vecs.push_back('{6'b100000, 6'b000000, 0, 0, 0, 5, 1, 0});  // lb
    vecs.push_back('{6'b101001, 6'b000000, 0, 0, 0, 4, 0, 0});  // sh
`else
    vecs.push_back('{6'b100000, 6'b000000, 0, 0, 0, 3, 0, 1});  // lb -> illegal
    vecs.push_back('{6'b101001, 6'b000000, 0, 0, 0, 3, 0, 1});  // sh -> illegal
`endif
    vecs.push_back('{6'b000000, 6'b100101, 1, 0, 0, 4, 1, 0});  // or

    do_reset(3);
    foreach (vecs[i]) run_instr(vecs[i], 1'b0, $sformatf("v%0d", i));

    // Store stalled in MEM_WR, then reset mid-instruction.
    ab = '{6'b101011, 6'b000000, 0, 0, 2, 0, 0, 0};
    run_instr(ab, 1'b1, "abort_sw");
    #2;
    check_int("mem_write_before_reset", int'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    check_int("mem_write_async_reset", int'(mem_write), 0);
    check_int("state_async_reset", int'(state), ST_IDLE);
    check_int("reg_write_async_reset", int'(reg_write), 0);
    do_reset(1);

    run_instr(vecs[0], 1'b0, "add_after_reset");
    step(ST_FETCH, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
